// File: rtl/mux_pkg.sv
// Shared types and constants for the 4-channel round-robin select arbiter
// and the 4->1 data mux that it steers.
package mux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_CH-1:0] sel_onehot(input sel_t s);
    logic [N_CH-1:0] one;
    one = {{(N_CH-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick4.sv
// Rotating-priority search: first asserted request at or after ptr,
// wrapping modulo 4.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output sel_t            idx,
  output logic            any
);

  // Walk from the farthest offset down so the nearest match is the last to win.
  always_comb begin
    idx = ptr;
    any = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[ptr + sel_t'(k)]) begin
        idx = ptr + sel_t'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing the registered select, one-hot grant and
// grant-valid for the downstream 4->1 mux, with a bounded hold per grant.
module rr_sel_arbiter
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            done,
  output sel_t            sel,
  output logic [N_CH-1:0] gnt,
  output logic            gnt_valid
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  arb_state_t      state_q, state_d;
  sel_t            ptr_q, ptr_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  sel_t            sel_q, sel_d;
  logic [N_CH-1:0] gnt_q, gnt_d;
  logic            vld_q, vld_d;

  sel_t            pick_ptr;
  sel_t            pick_idx;
  logic            pick_any;
  logic            release_w;

  // One picker serves both paths: from IDLE it searches from ptr, on a
  // release it searches from the slot just after the outgoing grantee.
  assign pick_ptr  = (state_q == GRANT) ? sel_q + sel_t'(1) : ptr_q;
  assign release_w = done || !req[sel_q] || (hold_cnt_q == HOLD_LAST);

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    vld_d      = vld_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          sel_d      = pick_idx;
          gnt_d      = sel_onehot(pick_idx);
          vld_d      = 1'b1;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        if (!release_w) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          ptr_d = pick_ptr;
          if (pick_any) begin
            sel_d      = pick_idx;
            gnt_d      = sel_onehot(pick_idx);
            vld_d      = 1'b1;
            hold_cnt_d = 8'd0;
          end else begin
            // sel keeps its last code; only the grant qualifiers drop.
            state_d    = IDLE;
            gnt_d      = '0;
            vld_d      = 1'b0;
            hold_cnt_d = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= 8'd0;
      sel_q      <= '0;
      gnt_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      vld_q      <= vld_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (HOLD_MAX = 4) with a scoreboard queue
// and a mux fed from the arbiter's select.
module tb_rr_sel_arbiter;

  typedef struct {
    logic       vld;
    logic [1:0] sel;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;

  logic [7:0] ch_data [4];
  logic [7:0] mux_out;

  exp_t exp_q [$];
  int   checks;
  int   failures;

  rr_sel_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  assign ch_data[0] = 8'h11;
  assign ch_data[1] = 8'h22;
  assign ch_data[2] = 8'h33;
  assign ch_data[3] = 8'h44;
  assign mux_out    = ch_data[sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Monitor: one expected entry per cycle, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt_valid", int'(gnt_valid), int'(e.vld));
        chk("sel", int'(sel), int'(e.sel));
        chk("gnt", int'(gnt), e.vld ? (1 << e.sel) : 0);
        if (e.vld)
          chk("mux_out", int'(mux_out), 8'h11 * (int'(e.sel) + 1));
      end
    end
  end

  // Drive inputs on the falling edge; expectation is for after the next rising edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic d,
                      input logic ev, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    e.vld = ev;
    e.sel = es;
    exp_q.push_back(e);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;

    // reset held with all requests up, then first grant to channel 0
    step(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b1111, 1'b0, 1'b1, 2'd0);

    // rotation with done every grant cycle
    step(1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);
    step(1'b0, 4'b1111, 1'b1, 1'b1, 2'd2);
    step(1'b0, 4'b1111, 1'b1, 1'b1, 2'd3);
    step(1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
    step(1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);

    // request drop to IDLE; ptr=2 so 4'b0011 resolves to channel 0
    step(1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
    step(1'b0, 4'b0011, 1'b0, 1'b1, 2'd0);

    // lone requester 2 held across a hold-budget expiry
    step(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
    // channel 3 joins; served when the current window ends
    step(1'b0, 4'b1100, 1'b0, 1'b1, 2'd2);
    step(1'b0, 4'b1100, 1'b0, 1'b1, 2'd3);

    // mid-grant reset; ptr back to 0 makes the next grant channel 0
    step(1'b1, 4'b1100, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b1111, 1'b0, 1'b1, 2'd0);

    // release to IDLE, done ignored while idle, lone requester re-grant on done
    step(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
    step(1'b0, 4'b1000, 1'b0, 1'b1, 2'd3);
    step(1'b0, 4'b1000, 1'b1, 1'b1, 2'd3);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
